// File: rtl/rv32_pkg.sv
// Shared RV32M definitions: funct3 encodings, muldiv FSM states and special-case constants.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/rv32_sign_fix.sv
// Conditional two's-complement negate; also yields |val| when is_signed and val is negative.
module rv32_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         is_signed,
    input  logic         force_neg,
    output logic [W-1:0] res
);

    logic neg;

    assign neg = force_neg | (is_signed & val[W-1]);
    assign res = neg ? -val : val;

endmodule

// File: rtl/rv32im_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle).
// Optional RV32_MULDIV_FAST_MUL_EN: single-cycle multiply, divide unchanged.
module rv32im_muldiv
    import rv32_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            we_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] result_o
);

    state_e            state, state_nxt;
    logic [4:0]        cnt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   acc, lo, op_b;
    logic              neg_q, neg_r;

    logic              accept, a_sgn, b_sgn, na, nb;
    logic              is_div_in, div0, ovf, early, fast_mul;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result_sel;

    assign accept    = valid_i & ready_o;
    assign ready_o   = (state == IDLE);
    assign busy_o    = (state != IDLE);
    assign is_div_in = funct3_i[2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3_i)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F3_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign na    = a_sgn & rs1_val_i[XLEN-1];
    assign nb    = b_sgn & rs2_val_i[XLEN-1];
    assign div0  = is_div_in & (rs2_val_i == '0);
    assign ovf   = is_div_in & b_sgn & (rs1_val_i == INT_MIN) & (rs2_val_i == '1);
    assign early = div0 | ovf;

`ifdef RV32_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    // Sign-extended 33-bit operands; the low 64 bits of the product are sign-agnostic.
    assign fast_a    = {{XLEN{na}}, rs1_val_i};
    assign fast_b    = {{XLEN{nb}}, rs2_val_i};
    assign fast_prod = fast_a * fast_b;
    assign fast_mul  = ~is_div_in;
`else
    assign fast_mul  = 1'b0;
`endif

    rv32_sign_fix #(.W(XLEN)) u_fix_a (.val(rs1_val_i), .is_signed(a_sgn), .force_neg(1'b0), .res(mag_a));
    rv32_sign_fix #(.W(XLEN)) u_fix_b (.val(rs2_val_i), .is_signed(b_sgn), .force_neg(1'b0), .res(mag_b));

    // Product lives in {acc, lo}; the divide keeps remainder in acc and shifts quotient into lo.
    assign mul_sum     = {1'b0, acc} + (lo[0] ? {1'b0, op_b} : '0);
    assign div_shift   = {acc, lo[XLEN-1]};
    assign div_ge      = div_shift >= {1'b0, op_b};
    assign div_rem_nxt = div_ge ? (div_shift[XLEN-1:0] - op_b) : div_shift[XLEN-1:0];

    rv32_sign_fix #(.W(2*XLEN)) u_fix_p (.val({acc, lo}), .is_signed(1'b0), .force_neg(neg_q), .res(prod_fix));
    rv32_sign_fix #(.W(XLEN))   u_fix_q (.val(lo),        .is_signed(1'b0), .force_neg(neg_q), .res(quot_fix));
    rv32_sign_fix #(.W(XLEN))   u_fix_r (.val(acc),       .is_signed(1'b0), .force_neg(neg_r), .res(rem_fix));

    always_comb begin
        result_sel = prod_fix[XLEN-1:0];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: result_sel = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_sel = quot_fix;
            F3_REM, F3_REMU:              result_sel = rem_fix;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (early | fast_mul) ? FIN : CALC;
            CALC: begin
                if (flush_i)            state_nxt = IDLE;
                else if (cnt == 5'd31)  state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            f3_q      <= F3_MUL;
            rd_q      <= '0;
            acc       <= '0;
            lo        <= '0;
            op_b      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            we_o      <= 1'b0;
            rd_addr_o <= '0;
            result_o  <= '0;
        end else begin
            we_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    f3_q  <= funct3_i;
                    rd_q  <= rd_addr_i;
                    cnt   <= '0;
                    op_b  <= mag_b;
                    acc   <= '0;
                    lo    <= mag_a;
                    neg_q <= na ^ nb;
                    neg_r <= na;
                    // Early cases preload the final quotient/remainder with no sign correction.
                    if (div0) begin
                        lo    <= DIV0_QUOT;
                        acc   <= rs1_val_i;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (ovf) begin
                        lo    <= INT_MIN;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
`ifdef RV32_MULDIV_FAST_MUL_EN
                    else if (fast_mul) begin
                        {acc, lo} <= fast_prod;
                        neg_q     <= 1'b0;
                    end
`endif
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (f3_q[2]) begin
                        acc <= div_rem_nxt;
                        lo  <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                FIN: if (!flush_i) begin
                    we_o      <= 1'b1;
                    rd_addr_o <= rd_q;
                    result_o  <= result_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_muldiv.sv
// Self-checking bench for rv32im_muldiv: directed vector table, corner sequences, random ops vs model.
module tb_rv32im_muldiv;
    import rv32_pkg::*;

`ifdef RV32_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int MAX_WAIT = 100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        ready_o;
    logic        busy_o;
    logic        we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_pass   = 0;

    rv32im_muldiv dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .funct3_i  (funct3_i),
        .rs1_val_i (rs1_val_i),
        .rs2_val_i (rs2_val_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .we_o      (we_o),
        .rd_addr_o (rd_addr_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference model straight from the RV32M arithmetic definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f3)
            F3_MUL:    begin p = ua * ub;           return p[31:0];  end
            F3_MULH:   begin p = sa * sb;           return p[63:32]; end
            F3_MULHSU: begin p = sa * $signed(ub);  return p[63:32]; end
            F3_MULHU:  begin p = ua * ub;           return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive a request, let it be accepted at the next edge, then scramble the inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        valid_i   = 1'b1;
        funct3_i  = f3;
        rs1_val_i = a;
        rs2_val_i = b;
        rd_addr_i = rd;
        @(posedge clk_i);
        #1;
        valid_i   = 1'b0;
        funct3_i  = 3'($urandom);
        rs1_val_i = $urandom;
        rs2_val_i = $urandom;
        rd_addr_i = 5'($urandom);
    endtask

    // Returns cycles from accept to we_o, or 0 if no strobe within the bound.
    task automatic wait_we(output int lat);
        lat = 0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(posedge clk_i);
            #1;
            if (we_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic [31:0] exp, input int exp_lat);
        int lat;
        check({name, " ready"}, 64'(ready_o), 64'd1);
        issue(f3, a, b, rd);
        wait_we(lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(result_o), 64'(exp));
        check({name, " rd"}, 64'(rd_addr_o), 64'(rd));
        @(posedge clk_i);
        #1;
        check({name, " we pulse"}, 64'(we_o), 64'd0);
    endtask

    initial begin
        int lat;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 33};
        vecs[3]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{F3_DIVU,   32'd100,        32'd7,         5'd5,  32'd14,        33};
        vecs[5]  = '{F3_REMU,   32'd100,        32'd7,         5'd6,  32'd2,         33};
        vecs[6]  = '{F3_DIV,    32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, 1};
        vecs[7]  = '{F3_REM,    32'd5,          32'd0,         5'd8,  32'd5,         1};
        vecs[8]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1};
        vecs[9]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'd0,         1};
        vecs[10] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd11, 32'h4000_0000, MUL_LAT};
        vecs[11] = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd12, 32'hFFFF_FFFF, MUL_LAT};
        vecs[12] = '{F3_DIVU,   32'd5,          32'd0,         5'd0,  32'hFFFF_FFFF, 1};
        vecs[13] = '{F3_REMU,   32'd7,          32'd0,         5'd31, 32'd7,         1};
        vecs[14] = '{F3_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, MUL_LAT};
        vecs[15] = '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         33};
        vecs[16] = '{F3_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33};

        rst_i     = 1'b1;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        funct3_i  = '0;
        rs1_val_i = '0;
        rs2_val_i = '0;
        rd_addr_i = '0;

        #12;
        check("reset ready", 64'(ready_o), 64'd1);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset we", 64'(we_o), 64'd0);
        check("reset rd", 64'(rd_addr_o), 64'd0);
        check("reset result", 64'(result_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                      vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // Back-to-back: second op issued during the first op's we_o cycle.
        issue(F3_DIVU, 32'd1000, 32'd3, 5'd5);
        wait_we(lat);
        check("b2b first latency", 64'(lat), 64'd33);
        check("b2b first result", 64'(result_o), 64'd333);
        check("b2b first rd", 64'(rd_addr_o), 64'd5);
        check("b2b ready in we cycle", 64'(ready_o), 64'd1);
        issue(F3_MUL, 32'd6, 32'd7, 5'd9);
        check("b2b second accepted", 64'(busy_o), 64'd1);
        check("b2b we dropped", 64'(we_o), 64'd0);
        check("b2b first result held", 64'(result_o), 64'd333);
        check("b2b first rd held", 64'(rd_addr_o), 64'd5);
        wait_we(lat);
        check("b2b second latency", 64'(lat), 64'(MUL_LAT));
        check("b2b second result", 64'(result_o), 64'd42);
        check("b2b second rd", 64'(rd_addr_o), 64'd9);
        @(posedge clk_i);
        #1;

        // Asynchronous reset in the middle of a divide.
        issue(F3_DIVU, 32'd12345, 32'd7, 5'd3);
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst ready", 64'(ready_o), 64'd1);
        check("midrst busy", 64'(busy_o), 64'd0);
        check("midrst we", 64'(we_o), 64'd0);
        check("midrst rd", 64'(rd_addr_o), 64'd0);
        check("midrst result", 64'(result_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wait_we(lat);
        check("midrst no we", 64'(lat), 64'd0);

        // Flush in CALC cycle 10 while valid_i is also high.
        issue(F3_DIV, 32'hFFFF_F000, 32'd13, 5'd7);
        repeat (10) @(posedge clk_i);
        #1;
        check("flush in calc", 64'(busy_o), 64'd1);
        flush_i   = 1'b1;
        valid_i   = 1'b1;
        funct3_i  = F3_DIV;
        rs1_val_i = 32'd5;
        rs2_val_i = 32'd0;
        rd_addr_i = 5'd1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush ready", 64'(ready_o), 64'd1);
        check("flush busy", 64'(busy_o), 64'd0);
        check("flush we", 64'(we_o), 64'd0);
        wait_we(lat);
        check("flush no we", 64'(lat), 64'd0);
        run_check("post flush", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            rd = 5'($urandom);
            run_check($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b),
                      f3, a, b, rd, ref_op(f3, a, b), ref_lat(f3, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32im_muldiv.md
# rv32im_muldiv

Iterative RV32M multiply/divide unit sitting between operand read and writeback. It consumes the rs1/rs2 values read from `rv32im_regfile` plus the destination index. It produces a one-cycle write request (`we_o`, `rd_addr_o`, `result_o`) that drives the register file write port directly. Multiplies and divides are computed one bit per cycle; divide-by-zero and signed overflow complete early.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  operation request; accepted when `valid_i & ready_o`
- funct3_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val_i  in  32  operand A (dividend/multiplicand)
- rs2_val_i  in  32  operand B (divisor/multiplier)
- rd_addr_i  in  5  destination register index
- flush_i  in  1  synchronous abort of the in-flight operation
- ready_o  out  1  high only in IDLE
- busy_o  out  1  high in CALC or FIN
- we_o  out  1  one-cycle result strobe to the register file write enable
- rd_addr_o  out  5  destination index, valid with `we_o`
- result_o  out  32  result, valid with `we_o`, held until next result

## Operation
- States: IDLE, CALC, FIN.
- IDLE:
  - On accept, latch funct3, rd_addr and operand magnitudes.
  - Signed ops take |x|, with the result sign recorded. MULHSU treats only rs1 as signed.
  - Next state is CALC with a 5-bit counter of 0, or FIN for the early cases.
- CALC, multiply: shift-add on a 64-bit product, one multiplier bit per cycle.
- CALC, divide: restoring division, 33-bit partial remainder, one quotient bit per cycle.
- CALC exits to FIN after 32 iterations, when the counter wraps from 31.
- FIN:
  - Apply sign correction (two's complement of the 64-bit product or of the quotient/remainder).
  - Select the result: MUL = low 32 bits; MULH, MULHSU, MULHU = high 32 bits; DIV, DIVU = quotient; REM, REMU = remainder.
  - REM sign follows the dividend.
  - Register `result_o` and `rd_addr_o`, pulse `we_o`, go to IDLE.
- Early cases (IDLE→FIN directly, no CALC):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- rd_addr_o = 0 is still strobed. Discarding x0 writes is the register file's job.
- flush_i:
  - Forces IDLE on the next edge and suppresses `we_o`.
  - Takes priority over a simultaneous `valid_i` (no accept that cycle).
  - Ignored in IDLE.

## Timing
- Reset values: state IDLE, ready_o 1, busy_o 0, we_o 0, rd_addr_o 0, result_o 0, counter 0.
- rst_i asserted mid-operation drops the operation immediately, with no `we_o`.
- Accept at edge E0. Iterative path: CALC for E1..E32, FIN at E32, `we_o` high for the cycle after E33.
- Latency is 33 cycles from accept to `we_o`.
- Early path: `we_o` is high for the cycle after E1.
- `we_o` is high for exactly one cycle; there is no backpressure.
- `ready_o` is already high in the `we_o` cycle, so back-to-back issue is allowed.
- Operands are not sampled after E0; `rs*_val_i` may change freely.

## Configuration
- `RV32_MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiply in IDLE→FIN. Latency is 1 cycle, like the early cases. Divide is unchanged.
- Undefined: all multiplies use the 32-cycle shift-add path; no hardware multiplier is inferred.

## Structure
- The shared package `rv32_pkg` holds:
  - funct3 encodings (`F3_MUL` … `F3_REMU`)
  - the state encoding (IDLE/CALC/FIN)
  - XLEN
  - the constants `DIV0_QUOT = 32'hFFFFFFFF` and `INT_MIN = 32'h80000000`
- Sub-module: `rv32_sign_fix`, which does the combinational conditional negate and the signed/unsigned magnitude extraction. It is used on input and in FIN.

## Test plan
- MUL 7 × −3 (0xFFFFFFFD) → `we_o` 33 cycles after accept, result 0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. All three: `we_o` one cycle after accept.
- Back-to-back: issue a second op while `we_o` is high → accepted; its rd_addr/result follow 33 cycles later, and the first result is not corrupted.
- flush_i at CALC cycle 10 with `valid_i` high → no `we_o`, ready_o 1 next cycle, no accept on the flush cycle.
- rst_i pulsed mid-CALC → all outputs at reset values immediately, no `we_o`. With `RV32_MULDIV_FAST_MUL_EN`: MULH 0x80000000 × 0x80000000 → 0x40000000 one cycle after accept.
